// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared types and glyph table for the seven-segment scan driver
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  // Glyphs are active-low abc_defg: bit 6 = a, bit 0 = g.
  localparam seg_t SEG_OFF = 7'b111_1111;
  localparam seg_t GLYPH_0 = 7'b000_0001;
  localparam seg_t GLYPH_1 = 7'b100_1111;
  localparam seg_t GLYPH_2 = 7'b001_0010;
  localparam seg_t GLYPH_3 = 7'b000_0110;
  localparam seg_t GLYPH_4 = 7'b100_1100;
  localparam seg_t GLYPH_5 = 7'b010_0100;
  localparam seg_t GLYPH_6 = 7'b010_0000;
  localparam seg_t GLYPH_7 = 7'b000_1111;
  localparam seg_t GLYPH_8 = 7'b000_0000;
  localparam seg_t GLYPH_9 = 7'b000_1100;
  localparam seg_t GLYPH_A = 7'b000_1000;
  localparam seg_t GLYPH_B = 7'b110_0000;
  localparam seg_t GLYPH_C = 7'b011_0001;
  localparam seg_t GLYPH_D = 7'b100_0010;
  localparam seg_t GLYPH_E = 7'b011_0000;
  localparam seg_t GLYPH_F = 7'b011_1000;

  typedef enum logic {GAP, DRIVE} scan_state_t;

endpackage

// File: rtl/sevenseg_glyph.sv
// rtl/sevenseg_glyph.sv - nibble to active-low seven-segment glyph decoder
module sevenseg_glyph
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = hex_mode ? GLYPH_A : SEG_OFF;
      4'hB: glyph = hex_mode ? GLYPH_B : SEG_OFF;
      4'hC: glyph = hex_mode ? GLYPH_C : SEG_OFF;
      4'hD: glyph = hex_mode ? GLYPH_D : SEG_OFF;
      4'hE: glyph = hex_mode ? GLYPH_E : SEG_OFF;
      default: glyph = hex_mode ? GLYPH_F : SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// rtl/sevenseg_scan_driver.sv - time-multiplexed seven-segment scanner with gap and frame-synchronous load
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int GAP_CYCLES       = 64,
  parameter bit HEX_MODE         = 1'b0,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [6:0]            SEG_OFF_PIN   = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic                  DP_OFF_PIN    = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF_PIN = DIGIT_ACTIVE_LOW ? '1 : '0;

  scan_state_t             state;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] shadow_val, active_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic                    pending;

  logic                    gap_end, drive_end, transfer;
  logic [4*NUM_DIGITS-1:0] cur_val;
  logic [NUM_DIGITS-1:0]   cur_dp;
  logic [3:0]              nibble;
  logic [6:0]              glyph;
  logic                    digit_dark;
  logic [6:0]              seg_pin;
  logic                    dp_pin;
  logic [NUM_DIGITS-1:0]   digit_pin;
  logic [IDX_W-1:0]        idx_next;

  assign gap_end   = (state == GAP)   && (cnt == CNT_W'(GAP_CYCLES - 1));
  assign drive_end = (state == DRIVE) && (cnt == CNT_W'(REFRESH_DIV - 1));
  assign transfer  = enable && gap_end && (idx == '0) && pending;

  // The digit being entered on a transfer edge must already show the new frame's data.
  assign cur_val = transfer ? shadow_val : active_val;
  assign cur_dp  = transfer ? shadow_dp  : active_dp;
  assign nibble  = cur_val[4*int'(idx) +: 4];

  sevenseg_glyph u_glyph (
    .nibble   (nibble),
    .hex_mode (HEX_MODE),
    .glyph    (glyph)
  );

  // A digit is a leading zero when it and everything above it is zero.
  assign digit_dark = blank_lz && (idx != '0) && ((cur_val >> (4*int'(idx))) == '0);

  always_comb begin
    seg_pin   = digit_dark ? SEG_OFF : glyph;
    seg_pin   = SEG_ACTIVE_LOW ? seg_pin : ~seg_pin;
    dp_pin    = SEG_ACTIVE_LOW ? ~cur_dp[idx] : cur_dp[idx];
    digit_pin = NUM_DIGITS'(1) << idx;
    digit_pin = DIGIT_ACTIVE_LOW ? ~digit_pin : digit_pin;
    idx_next  = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= GAP;
      idx        <= '0;
      cnt        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      segments   <= SEG_OFF_PIN;
      dp         <= DP_OFF_PIN;
      digit_en   <= DIGIT_OFF_PIN;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end else if (transfer) begin
        pending    <= 1'b0;
      end

      if (!enable) begin
        state      <= GAP;
        idx        <= '0;
        cnt        <= '0;
        segments   <= SEG_OFF_PIN;
        dp         <= DP_OFF_PIN;
        digit_en   <= DIGIT_OFF_PIN;
        frame_done <= 1'b0;
      end else begin
        case (state)
          GAP: begin
            frame_done <= 1'b0;
            if (gap_end) begin
              state    <= DRIVE;
              cnt      <= '0;
              segments <= seg_pin;
              dp       <= dp_pin;
              digit_en <= digit_pin;
              if (transfer) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            if (drive_end) begin
              state      <= GAP;
              cnt        <= '0;
              idx        <= idx_next;
              segments   <= SEG_OFF_PIN;
              dp         <= DP_OFF_PIN;
              digit_en   <= DIGIT_OFF_PIN;
              frame_done <= (idx == IDX_W'(NUM_DIGITS - 1));
            end else begin
              cnt      <= cnt + 1'b1;
              segments <= seg_pin;
              dp       <= dp_pin;
              digit_en <= digit_pin;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a packed BCD or hex value through a load strobe and decodes one digit at a time. Each digit is driven for a programmable dwell period, with an all-off gap between digits to suppress ghosting. It sits between the NES controller-state/score logic and the board display pins, and replaces per-digit static decoders.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clk cycles each digit is driven (>=2)
GAP_CYCLES, 64, clk cycles of all-digits-off between digits (>=1)
HEX_MODE, 0, 0: nibbles 10-15 blank; 1: nibbles 10-15 show A,b,C,d,E,F
SEG_ACTIVE_LOW, 1, 1: segments/dp driven low = lit; 0: inverted
DIGIT_ACTIVE_LOW, 1, 1: digit_en low = digit selected; 0: inverted

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  scanning enabled; low forces display dark
load  in  1  single-cycle strobe; capture value/dp_in
value  in  4*NUM_DIGITS  packed nibbles; digit 0 = value[3:0] = rightmost
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_lz  in  1  suppress leading zeros (sampled live)
segments  out  7  abc_defg, segments[6]=a .. segments[0]=g
dp  out  1  decimal point for the selected digit
digit_en  out  NUM_DIGITS  one-hot digit select
frame_done  out  1  one-cycle pulse when the last digit's dwell ends

Behaviour:
- Reset (async assert, sync release): segments/dp = off (all-ones when active-low), digit_en = all deselected, frame_done=0, shadow and active registers = 0, state=GAP, idx=0, cnt=0.
- FSM states: GAP and DRIVE. GAP: digit_en deselected, segments/dp off; after GAP_CYCLES cycles -> DRIVE. DRIVE: digit_en selects idx, segments/dp show glyph of active[idx]; after REFRESH_DIV cycles -> GAP with idx+1. idx wraps NUM_DIGITS-1 -> 0.
- frame_done: high for exactly the first GAP cycle after DRIVE of idx=NUM_DIGITS-1.
- Frame period: NUM_DIGITS*(GAP_CYCLES+REFRESH_DIV) cycles.
- All outputs are registered. The first DRIVE cycle after reset is cycle GAP_CYCLES+1 after release.
- Load: value/dp_in go into shadow on the clock edge where load=1, and a pending flag is set. The active register updates from shadow only on the GAP->DRIVE transition with idx=0, which then clears pending. There is no tearing within a frame. A second load before transfer overwrites shadow; last wins. A load coincident with the transfer edge: the old shadow transfers, the new value is captured, and pending stays set.
- Glyphs (active-low abc_defg): 0 000_0001, 1 100_1111, 2 001_0010, 3 000_0110, 4 100_1100, 5 010_0100, 6 010_0000, 7 000_1111, 8 000_0000, 9 000_1100.
- HEX_MODE=1 adds A 000_1000, b 110_0000, C 011_0001, d 100_0010, E 011_0000, F 011_1000. With HEX_MODE=0, nibbles 10-15 = 111_1111.
- SEG_ACTIVE_LOW=0 inverts segments and dp. DIGIT_ACTIVE_LOW=0 inverts digit_en.
- Leading-zero blanking: with blank_lz=1, digit i>0 is dark when active[i] and all higher nibbles are 0. Digit 0 is never blanked. dp is still honoured on blanked digits.
- enable=0: next edge forces state=GAP, idx=0, cnt=0, outputs off, no frame_done. Shadow still accepts load. When enable returns to 1, scanning restarts as after reset, and the first DRIVE transfers pending.
- reset_n mid-operation: outputs go off immediately (asynchronously), and all registers clear including pending.

Decomposition:
- sevenseg_pkg holds:
  - seg_t (logic [6:0]);
  - SEG_OFF (7'b111_1111);
  - glyph constants GLYPH_0..GLYPH_F;
  - scan_state_t enum {GAP, DRIVE}.
- Sub-module sevenseg_glyph: combinational nibble + hex_mode -> seg_t, active-low, used once on the muxed nibble. Polarity inversion and blanking are applied in the top level before the output register.

Test Plan:
(All with NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1, default polarities.)
1. Release reset, enable=1 -> cycle 1 digit_en=1111, segments=111_1111. Cycle 2: digit_en=1110, segments=000_0001 held 4 cycles. Then 1 gap cycle, then 1101.
2. load value=16'h1234, dp_in=4'b0100 -> next frame shows:
   - digit0 100_1100 (digit_en 1110);
   - digit1 000_0110;
   - digit2 001_0010 with dp=0;
   - digit3 100_1111.
   frame_done pulses every 20 cycles.
3. Mid-frame load 16'h0007 while digit2 is driven, blank_lz=1 -> digits 2,3 keep old glyphs until frame_done. The next frame shows digits 3..1 at 111_1111 and digit0 at 000_1111.
4. Nibble 4'hA with HEX_MODE=0 -> 111_1111; with HEX_MODE=1 -> 000_1000. Nibble 4'hF with HEX_MODE=1 -> 011_1000.
5. Drop reset_n during digit2 DRIVE -> same cycle digit_en=1111, segments=111_1111. After release, digit0 shows 000_0001 (active cleared).
6. Deassert enable for 10 cycles mid-frame with a load inside -> display dark, no frame_done. After re-enable, 1 gap cycle, then the loaded value from digit0.
